// File: rtl/pipe_rca_if.sv
// Streaming operand/result bundle for the pipelined ripple-carry adder.
// master = producer/consumer side, slave = the adder itself.
interface pipe_rca_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/pipe_rca.sv
// Pipelined ripple-carry adder/subtractor: one CW-bit chunk per stage, registered
// inter-chunk carry, global stall when the result is not taken.
module pipe_rca #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic       clk,
  input  logic       rst,
  pipe_rca_if.slave  bus
);
  localparam int CW = WIDTH / STAGES;

  logic stall;

  assign stall        = g_stage[STAGES-1].v_q && !bus.out_ready;
  assign bus.in_ready = !stall;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    // Operand bits still unprocessed when entering this stage.
    localparam int UIN = WIDTH - gi*CW;

    logic                   v_in;
    logic [UIN-1:0]         a_in;
    logic [UIN-1:0]         b_in;
    logic                   c_in;
    logic [CW:0]            add_w;
    logic [(gi+1)*CW-1:0]   s_d;

    logic                   v_q;
    logic                   c_q;
    logic [(gi+1)*CW-1:0]   s_q;

    if (gi == 0) begin : g_head
      assign v_in = bus.in_valid;
      assign a_in = bus.a;
      assign b_in = bus.b ^ {WIDTH{bus.sub}};
      assign c_in = bus.sub | bus.cin;
      assign s_d  = add_w[CW-1:0];
    end else begin : g_body
      assign v_in = g_stage[gi-1].v_q;
      assign a_in = g_stage[gi-1].g_fwd.a_q;
      assign b_in = g_stage[gi-1].g_fwd.b_q;
      assign c_in = g_stage[gi-1].c_q;
      assign s_d  = {add_w[CW-1:0], g_stage[gi-1].s_q};
    end

    assign add_w = {1'b0, a_in[CW-1:0]} + {1'b0, b_in[CW-1:0]} + {{CW{1'b0}}, c_in};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (!stall) begin
        v_q <= v_in;
        if (v_in) begin
          c_q <= add_w[CW];
          s_q <= s_d;
        end
      end
    end

    if (gi < STAGES-1) begin : g_fwd
      logic [UIN-CW-1:0] a_q;
      logic [UIN-CW-1:0] b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall && v_in) begin
          a_q <= a_in[UIN-1:CW];
          b_q <= b_in[UIN-1:CW];
        end
      end
    end else begin : g_tail
      // Carry into the MSB, recovered from the MSB sum bit and its operands.
      logic cmsb_d;
      logic cmsb_q;

      assign cmsb_d = add_w[CW-1] ^ a_in[CW-1] ^ b_in[CW-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cmsb_q <= 1'b0;
        end else if (!stall && v_in) begin
          cmsb_q <= cmsb_d;
        end
      end
    end
  end

  assign bus.out_valid = g_stage[STAGES-1].v_q;
  assign bus.s         = g_stage[STAGES-1].s_q;
  assign bus.cout      = g_stage[STAGES-1].c_q;
  assign bus.ovf       = g_stage[STAGES-1].c_q ^ g_stage[STAGES-1].g_tail.cmsb_q;
endmodule

// File: tb/tb_pipe_rca.sv
// Scoreboard bench for pipe_rca: directed 16/4 sequence plus 8/1 and 32/8 random sweeps.
module tb_pipe_rca;
  typedef struct {
    logic [63:0] s;
    logic        co;
    logic        ov;
    int          adv0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_rca_if #(.WIDTH(16)) bus0 ();
  pipe_rca_if #(.WIDTH(8))  bus1 ();
  pipe_rca_if #(.WIDTH(32)) bus2 ();

  pipe_rca #(.WIDTH(16), .STAGES(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  pipe_rca #(.WIDTH(8),  .STAGES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  pipe_rca #(.WIDTH(32), .STAGES(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  exp_t sb2[$];
  bit   acc [3];
  int   adv [3];
  int   popped [3];

  logic [63:0] last_s0;
  logic        last_co0, last_ov0;
  logic        obs0_ir;
  logic [15:0] obs0_s;
  logic        obs0_co;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  // Independent flat-width reference: full add plus a separate add of the low
  // WIDTH-1 bits to obtain the carry into the MSB.
  function automatic exp_t model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                 input logic ci, input logic sb);
    exp_t        m;
    logic [64:0] mask, lmask, be, full, lo;
    logic        ce;
    mask   = (65'd1 << w) - 65'd1;
    lmask  = mask >> 1;
    be     = (sb ? ~{1'b0, bv} : {1'b0, bv}) & mask;
    ce     = sb ? 1'b1 : ci;
    full   = ({1'b0, av} & mask) + be + {64'd0, ce};
    lo     = ({1'b0, av} & lmask) + (be & lmask) + {64'd0, ce};
    m.s    = full[63:0] & mask[63:0];
    m.co   = full[w];
    m.ov   = full[w] ^ lo[w-1];
    m.adv0 = 0;
    return m;
  endfunction

  task automatic eval_dut(input int d, input int w, input int stg,
                          input logic iv, input logic ir, input logic ovd, input logic orr,
                          input logic [63:0] av, input logic [63:0] bv, input logic ci, input logic sb,
                          input logic [63:0] sv, input logic co, input logic ovf_o);
    exp_t e;
    bit   have;
    if (ovd && orr) begin
      have = 1'b0;
      case (d)
        0: if (sb0.size() != 0) begin e = sb0.pop_front(); have = 1'b1; end
        1: if (sb1.size() != 0) begin e = sb1.pop_front(); have = 1'b1; end
        default: if (sb2.size() != 0) begin e = sb2.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
        chk($sformatf("dut%0d_unexpected_out", d), 64'(ovd), 64'd0);
      end else begin
        popped[d]++;
        chk($sformatf("dut%0d_s", d), sv, e.s);
        chk($sformatf("dut%0d_cout", d), 64'(co), 64'(e.co));
        chk($sformatf("dut%0d_ovf", d), 64'(ovf_o), 64'(e.ov));
        chk($sformatf("dut%0d_latency", d), 64'(adv[d] - e.adv0), 64'(stg));
        $display("dut%0d result s=%0h cout=%0b ovf=%0b (exp s=%0h cout=%0b ovf=%0b)",
                 d, sv, co, ovf_o, e.s, e.co, e.ov);
        if (d == 0) begin
          last_s0  = sv;
          last_co0 = co;
          last_ov0 = ovf_o;
        end
      end
    end
    acc[d] = iv && ir;
    if (acc[d]) begin
      e      = model(w, av, bv, ci, sb);
      e.adv0 = adv[d];
      case (d)
        0: sb0.push_back(e);
        1: sb1.push_back(e);
        default: sb2.push_back(e);
      endcase
    end
    if (!(ovd && !orr)) adv[d]++;
  endtask

  // One clock cycle: evaluate at the falling edge, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      eval_dut(0, 16, 4, bus0.in_valid, bus0.in_ready, bus0.out_valid, bus0.out_ready,
               64'(bus0.a), 64'(bus0.b), bus0.cin, bus0.sub, 64'(bus0.s), bus0.cout, bus0.ovf);
      eval_dut(1, 8, 1, bus1.in_valid, bus1.in_ready, bus1.out_valid, bus1.out_ready,
               64'(bus1.a), 64'(bus1.b), bus1.cin, bus1.sub, 64'(bus1.s), bus1.cout, bus1.ovf);
      eval_dut(2, 32, 8, bus2.in_valid, bus2.in_ready, bus2.out_valid, bus2.out_ready,
               64'(bus2.a), 64'(bus2.b), bus2.cin, bus2.sub, 64'(bus2.s), bus2.cout, bus2.ovf);
    end else begin
      for (int k = 0; k < 3; k++) acc[k] = 1'b0;
    end
    obs0_ir = bus0.in_ready;
    obs0_s  = bus0.s;
    obs0_co = bus0.cout;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [15:0] av, input logic [15:0] bv, input logic ci, input logic sb);
    int n;
    bus0.a = av; bus0.b = bv; bus0.cin = ci; bus0.sub = sb;
    bus0.in_valid = 1'b1;
    bus0.out_ready = 1'b1;
    tick();
    n = 0;
    while (!acc[0] && n < 20) begin
      tick();
      n++;
    end
    chk("accept_timeout", 64'(acc[0]), 64'd1);
    bus0.in_valid = 1'b0;
  endtask

  task automatic drain(output int n);
    n = 0;
    while ((sb0.size() + sb1.size() + sb2.size()) != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_timeout", 64'(sb0.size() + sb1.size() + sb2.size()), 64'd0);
  endtask

  initial begin
    int          n, i, c, p0, nd1, nd2;
    logic [15:0] sa [6];
    logic [15:0] sbv [6];
    logic        ssub [6];
    logic [15:0] hold_s;
    logic        hold_co;

    for (int k = 0; k < 3; k++) begin
      acc[k] = 1'b0; adv[k] = 0; popped[k] = 0;
    end
    bus0.in_valid = 0; bus0.a = '0; bus0.b = '0; bus0.cin = 0; bus0.sub = 0; bus0.out_ready = 1;
    bus1.in_valid = 0; bus1.a = '0; bus1.b = '0; bus1.cin = 0; bus1.sub = 0; bus1.out_ready = 1;
    bus2.in_valid = 0; bus2.a = '0; bus2.b = '0; bus2.cin = 0; bus2.sub = 0; bus2.out_ready = 1;

    // Reset state
    #2;
    chk("rst_out_valid", 64'(bus0.out_valid), 64'd0);
    chk("rst_s",         64'(bus0.s),         64'd0);
    chk("rst_cout",      64'(bus0.cout),      64'd0);
    chk("rst_ovf",       64'(bus0.ovf),       64'd0);
    chk("rst_in_ready",  64'(bus0.in_ready),  64'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Plain add and first-result latency
    send0(16'h1234, 16'h4321, 1'b0, 1'b0);
    drain(n);
    chk("t1_latency_cycles", 64'(n), 64'd4);
    chk("t1_s", last_s0, 64'h5555);
    chk("t1_cout", 64'(last_co0), 64'd0);
    chk("t1_ovf", 64'(last_ov0), 64'd0);

    // Carry through every chunk
    send0(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    drain(n);
    chk("t2_s", last_s0, 64'h0000);
    chk("t2_cout", 64'(last_co0), 64'd1);
    chk("t2_ovf", 64'(last_ov0), 64'd0);
    send0(16'h7FFF, 16'h0000, 1'b1, 1'b0);
    drain(n);
    chk("t3_s", last_s0, 64'h8000);
    chk("t3_cout", 64'(last_co0), 64'd0);
    chk("t3_ovf", 64'(last_ov0), 64'd1);

    // Subtract, cin ignored
    send0(16'h8000, 16'h0001, 1'b1, 1'b1);
    drain(n);
    chk("t4_s", last_s0, 64'h7FFF);
    chk("t4_cout", 64'(last_co0), 64'd1);
    chk("t4_ovf", 64'(last_ov0), 64'd1);
    send0(16'h0003, 16'h0005, 1'b0, 1'b1);
    drain(n);
    chk("t5_s", last_s0, 64'hFFFE);
    chk("t5_cout", 64'(last_co0), 64'd0);
    chk("t5_ovf", 64'(last_ov0), 64'd0);

    // Back-to-back stream with a 3-cycle consumer stall while results are waiting
    for (int k = 0; k < 6; k++) begin
      sa[k] = 16'($urandom); sbv[k] = 16'($urandom); ssub[k] = 1'($urandom);
    end
    p0 = popped[0];
    i = 0;
    c = 0;
    while (i < 6 && c < 30) begin
      bus0.a = sa[i]; bus0.b = sbv[i]; bus0.sub = ssub[i]; bus0.cin = 1'b1;
      bus0.in_valid  = 1'b1;
      bus0.out_ready = (c >= 4 && c <= 6) ? 1'b0 : 1'b1;
      tick();
      chk($sformatf("stream_in_ready_c%0d", c), 64'(obs0_ir), (c >= 4 && c <= 6) ? 64'd0 : 64'd1);
      if (c == 4) begin
        hold_s = obs0_s; hold_co = obs0_co;
      end else if (c == 5 || c == 6) begin
        chk($sformatf("stall_s_stable_c%0d", c), 64'(obs0_s), 64'(hold_s));
        chk($sformatf("stall_cout_stable_c%0d", c), 64'(obs0_co), 64'(hold_co));
      end
      if (acc[0]) i++;
      c++;
    end
    chk("stream_cycles", 64'(c), 64'd9);
    bus0.in_valid = 1'b0;
    bus0.out_ready = 1'b1;
    drain(n);
    chk("stream_results", 64'(popped[0] - p0), 64'd6);

    // Reset with three beats in flight
    for (int k = 0; k < 3; k++) begin
      bus0.a = 16'($urandom); bus0.b = 16'($urandom); bus0.sub = 1'b0; bus0.cin = 1'b0;
      bus0.in_valid = 1'b1;
      tick();
    end
    bus0.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(bus0.out_valid), 64'd0);
    chk("midrst_s",         64'(bus0.s),         64'd0);
    chk("midrst_in_ready",  64'(bus0.in_ready),  64'd1);
    sb0.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    p0 = popped[0];
    for (int k = 0; k < 6; k++) tick();
    send0(16'h00F0, 16'h0F10, 1'b0, 1'b0);
    drain(n);
    chk("postrst_latency_cycles", 64'(n), 64'd4);
    chk("postrst_s", last_s0, 64'h1000);
    chk("postrst_results", 64'(popped[0] - p0), 64'd1);

    // Random sweep on 8/1 and 32/8 with random flow control
    nd1 = 0;
    nd2 = 0;
    c = 0;
    while ((nd1 < 1000 || nd2 < 1000) && c < 20000) begin
      bus1.out_ready = ($urandom_range(0, 3) != 0);
      bus2.out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (acc[1]) nd1++;
      if (acc[2]) nd2++;
      if (acc[1] || !bus1.in_valid) begin
        bus1.in_valid = (nd1 < 1000) && ($urandom_range(0, 7) != 0);
        bus1.a = 8'($urandom); bus1.b = 8'($urandom);
        bus1.cin = 1'($urandom); bus1.sub = 1'($urandom);
      end
      if (acc[2] || !bus2.in_valid) begin
        bus2.in_valid = (nd2 < 1000) && ($urandom_range(0, 7) != 0);
        bus2.a = $urandom; bus2.b = $urandom;
        bus2.cin = 1'($urandom); bus2.sub = 1'($urandom);
      end
      c++;
    end
    chk("sweep8_beats", 64'(nd1), 64'd1000);
    chk("sweep32_beats", 64'(nd2), 64'd1000);
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b1;
    drain(n);
    chk("sweep8_results", 64'(popped[1]), 64'd1000);
    chk("sweep32_results", 64'(popped[2]), 64'd1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
